dram_model: RTL and testbench



---
 rtl/dram_model.sv | 189 ++++++++++++++++++
 tb/tb_dram_model.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/dram_model.sv
// Word-addressed memory responder with DRAM-like timing: banked open-page
// row tracking, hit/empty/conflict latencies and periodic refresh.
//
// state | meaning
// IDLE  | ready when no refresh is due; accepts re/we or starts refresh
// PRE   | precharging the conflicting row, T_RP cycles
// ACT   | activating the target row, T_RCD cycles
// CAS   | column access, T_CAS cycles; completes on the last one
// REF   | refresh, all banks closed, T_RFC cycles
module dram_model #(
    parameter int DEPTH_BITS = 10,
    parameter int COL_BITS   = 4,
    parameter int BANK_BITS  = 2,
    parameter int T_CAS      = 2,
    parameter int T_RCD      = 3,
    parameter int T_RP       = 3,
    parameter int T_REFI     = 512,
    parameter int T_RFC      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] addr,
    input  logic [63:0] din,
    output logic [63:0] dout,
    input  logic        re,
    input  logic        we,
    output logic        ready
);

    localparam int ROW_BITS = DEPTH_BITS - COL_BITS - BANK_BITS;
    localparam int NB       = 1 << BANK_BITS;
    localparam int CW       = 16;
    localparam int RW       = (T_REFI > 1) ? $clog2(T_REFI) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ACT,
        CAS,
        REF
    } state_t;

    state_t                state;
    logic [CW-1:0]         pcnt;
    logic [RW-1:0]         rcnt;
    logic                  refresh_pending;
    logic [NB-1:0]         bank_open;
    logic [ROW_BITS-1:0]   open_row [NB];
    logic [DEPTH_BITS-1:0] lat_w;
    logic [63:0]           lat_din;
    logic                  op_write;
    logic [63:0]           mem [0:(1<<DEPTH_BITS)-1];

    logic [DEPTH_BITS-1:0] in_w;
    logic [BANK_BITS-1:0]  in_bank;
    logic [ROW_BITS-1:0]   in_row;
    logic                  accept;
    logic                  wrap;
    logic                  refresh_due;
    logic                  phase_done;
    logic                  mem_we;
    logic                  unused_addr_bits;

    assign in_w             = addr[DEPTH_BITS-1:0];
    assign in_bank          = in_w[COL_BITS+BANK_BITS-1:COL_BITS];
    assign in_row           = in_w[DEPTH_BITS-1:COL_BITS+BANK_BITS];
    assign unused_addr_bits = ^addr[63:DEPTH_BITS];

    assign accept      = (state == IDLE) && ready && (re || we);
    assign wrap        = (rcnt == RW'(T_REFI - 1));
    // A wrap on this very edge counts as due so refresh starts without an
    // extra idle cycle and ready stays low exactly T_RFC cycles.
    assign refresh_due = refresh_pending || wrap;
    assign phase_done  = (pcnt == '0);
    assign mem_we      = (state == CAS) && phase_done && op_write;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[lat_w] <= lat_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            pcnt            <= '0;
            rcnt            <= '0;
            refresh_pending <= 1'b0;
            bank_open       <= '0;
            for (int i = 0; i < NB; i++) begin
                open_row[i] <= '0;
            end
            lat_w           <= '0;
            lat_din         <= '0;
            op_write        <= 1'b0;
            ready           <= 1'b1;
            dout            <= '0;
        end else begin
            rcnt <= wrap ? '0 : rcnt + 1'b1;
            if (wrap) begin
                refresh_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_w    <= in_w;
                        lat_din  <= din;
                        op_write <= we;
                        ready    <= 1'b0;
                        if (!bank_open[in_bank]) begin
                            state <= ACT;
                            pcnt  <= CW'(T_RCD - 1);
                        end else if (open_row[in_bank] == in_row) begin
                            state <= CAS;
                            pcnt  <= CW'(T_CAS - 1);
                        end else begin
                            state <= PRE;
                            pcnt  <= CW'(T_RP - 1);
                        end
                        bank_open[in_bank] <= 1'b1;
                        open_row[in_bank]  <= in_row;
                    end else if (refresh_due) begin
                        state           <= REF;
                        pcnt            <= CW'(T_RFC - 1);
                        ready           <= 1'b0;
                        refresh_pending <= 1'b0;
                        bank_open       <= '0;
                    end
                end

                PRE: begin
                    if (phase_done) begin
                        state <= ACT;
                        pcnt  <= CW'(T_RCD - 1);
                    end else begin
                        pcnt <= pcnt - 1'b1;
                    end
                end

                ACT: begin
                    if (phase_done) begin
                        state <= CAS;
                        pcnt  <= CW'(T_CAS - 1);
                    end else begin
                        pcnt <= pcnt - 1'b1;
                    end
                end

                CAS: begin
                    if (phase_done) begin
                        if (!op_write) begin
                            dout <= mem[lat_w];
                        end
                        // A refresh that came due during the access follows
                        // directly so ready never blips high in between.
                        if (refresh_due) begin
                            state           <= REF;
                            pcnt            <= CW'(T_RFC - 1);
                            ready           <= 1'b0;
                            refresh_pending <= 1'b0;
                            bank_open       <= '0;
                        end else begin
                            state <= IDLE;
                            ready <= 1'b1;
                        end
                    end else begin
                        pcnt <= pcnt - 1'b1;
                    end
                end

                REF: begin
                    if (phase_done) begin
                        state <= IDLE;
                        ready <= !refresh_due;
                    end else begin
                        pcnt <= pcnt - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_model.sv
// Directed bench for dram_model: latencies, data, address wrap, write
// priority, refresh timing and reset abort.
module tb_dram_model;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] addr = '0;
    logic [63:0] din = '0;
    logic [63:0] dout;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic        ready;

    int checks = 0;
    int errors = 0;
    int cyc;
    int n;
    int guard;

    dram_model dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .re    (re),
        .we    (we),
        .ready (ready)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the refresh counter wraps on edge 512*k.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts cycles ready stays low after the current posedge; ends on a negedge.
    task automatic count_low(output int cnt);
        cnt = 0;
        @(posedge clk); #1;
        re = 1'b0;
        we = 1'b0;
        while (ready !== 1'b1 && cnt < 200) begin
            cnt++;
            @(posedge clk); #1;
        end
        @(negedge clk);
    endtask

    // Issues one request from a negedge and checks its ready-low duration.
    task automatic access(input string tag, input logic w, input logic r,
                          input logic [63:0] a, input logic [63:0] d, input int exp_lat);
        int lat;
        check({tag, "_ready_before"}, {63'd0, ready}, 64'd1);
        addr = a;
        din  = d;
        we   = w;
        re   = r;
        count_low(lat);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        #12;
        check("reset_ready", {63'd0, ready}, 64'd1);
        check("reset_dout", dout, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        access("wr1_empty", 1'b1, 1'b0, 64'd1, 64'h0123456789abcdef, 5);
        access("rd1_hit", 1'b0, 1'b1, 64'd1, 64'd0, 2);
        check("rd1_data", dout, 64'h0123456789abcdef);

        access("wr257_conflict", 1'b1, 1'b0, 64'd257, 64'd123, 8);
        check("wr257_dout_held", dout, 64'h0123456789abcdef);
        access("rd257_hit", 1'b0, 1'b1, 64'd257, 64'd0, 2);
        check("rd257_data", dout, 64'd123);
        access("rd1_conflict", 1'b0, 1'b1, 64'd1, 64'd0, 8);
        check("rd1_conflict_data", dout, 64'h0123456789abcdef);

        access("wr1025_wrap", 1'b1, 1'b0, 64'd1025, 64'd5, 2);
        access("rd1_after_wrap", 1'b0, 1'b1, 64'd1, 64'd0, 2);
        check("rd1_wrap_data", dout, 64'd5);
        access("rw2_write_prio", 1'b1, 1'b1, 64'd2, 64'd9, 2);
        check("rw2_dout_held", dout, 64'd5);
        access("rd2", 1'b0, 1'b1, 64'd2, 64'd0, 2);
        check("rd2_data", dout, 64'd9);

        guard = 0;
        while (cyc != 511 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("idle_reach_511", 64'(cyc), 64'd511);
        check("idle_ready_pre_refresh", {63'd0, ready}, 64'd1);
        count_low(n);
        check("idle_refresh_len", 64'(n), 64'd8);
        access("rd1_after_refresh", 1'b0, 1'b1, 64'd1, 64'd0, 5);
        check("rd1_after_refresh_data", dout, 64'd5);

        guard = 0;
        while (cyc != 1023 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("reach_1023", 64'(cyc), 64'd1023);
        access("rd2_on_wrap", 1'b0, 1'b1, 64'd2, 64'd0, 10);
        check("rd2_on_wrap_data", dout, 64'd9);

        access("rd1_open_bank", 1'b0, 1'b1, 64'd1, 64'd0, 5);
        check("rd1_open_bank_data", dout, 64'd5);
        check("abort_ready_before", {63'd0, ready}, 64'd1);
        addr = 64'd257;
        din  = 64'hdead;
        we   = 1'b1;
        @(posedge clk); #1;
        we = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        check("abort_busy", {63'd0, ready}, 64'd0);
        rst = 1'b1;
        #1;
        check("abort_ready", {63'd0, ready}, 64'd1);
        check("abort_dout", dout, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        access("rd257_after_abort", 1'b0, 1'b1, 64'd257, 64'd0, 5);
        check("rd257_old_value", dout, 64'd123);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
